mult_8_share_arbiter: RTL and testbench
=======================================

Name: mult_8_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one mult_8 hard block between N_REQ requesters. It sits between requester logic in the fabric and a single mult_8 tile. It accepts one operand pair at a time over a valid/ready handshake and drives mult_8_a and mult_8_b. It waits the configured multiplier latency, then captures mult_8_out and returns the product tagged with the requester index over a valid/ready response channel.

Parameters:
N_REQ, 4, number of requesters (2..8).
ID_W, 2, width of rsp_id; must equal clog2(N_REQ).
MULT_LATENCY, 1, edges between operands appearing on mult_8_a/b and a valid mult_8_out (0 = combinational multiplier).

Ports:
mult_8_clk  input  1  single clock; every register is rising-edge.
pReset  input  1  asynchronous, active-high reset.
req_valid  input  N_REQ  bit i: requester i has an operand pair.
req_ready  output  N_REQ  one-hot or zero; bit i: pair i accepted this cycle.
req_a  input  8*N_REQ  requester i operand A in slice [8i+7:8i].
req_b  input  8*N_REQ  requester i operand B in slice [8i+7:8i].
mult_8_a  output  8  operand A to the mult_8 tile.
mult_8_b  output  8  operand B to the mult_8 tile.
mult_8_out  input  16  product from the mult_8 tile.
rsp_valid  output  1  product available.
rsp_ready  input  1  consumer accepts the product.
rsp_data  output  16  product, unsigned 8x8.
rsp_id  output  ID_W  index of the requester that owns rsp_data.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release). State=IDLE, rr_ptr=0, latency counter=0. mult_8_a=0, mult_8_b=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, req_ready=0.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If any req_valid is high, grant g = first set bit searching from rr_ptr upward, with wrap.
  - req_ready[g]=1 combinationally in that cycle; all other bits are 0. req_ready is never high outside IDLE.
  - At that edge (acceptance edge T): mult_8_a<=req_a slice g, mult_8_b<=req_b slice g, rsp_id<=g, rr_ptr<=(g+1) mod N_REQ, counter<=MULT_LATENCY, go to WAIT.
  - If no req_valid is high, stay in IDLE.
- WAIT:
  - If counter!=0, decrement it.
  - If counter==0, rsp_data<=mult_8_out, rsp_valid<=1, go to RESP.
  - rsp_valid therefore rises at edge T+MULT_LATENCY+1.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_valid&&rsp_ready at an edge.
  - At that edge: rsp_valid<=0, go to IDLE.
  - No new acceptance occurs in the same cycle as the response handshake. Minimum spacing between acceptances is MULT_LATENCY+3 cycles.
- mult_8_a and mult_8_b hold their operands from acceptance through RESP and after. They change only at the next acceptance.
- Arithmetic is unsigned: 8x8 gives a 16-bit result with no truncation. The block passes mult_8_out through unmodified.
- rr_ptr advances only on a grant. A requester that keeps req_valid high is served at most once per N_REQ grants while others are pending.
- req_valid deasserted by a requester before it is granted is legal; that requester is simply skipped.
- Requester operands are sampled only at the acceptance edge. Changes in WAIT or RESP are ignored.
- pReset asserted mid-operation (WAIT or RESP):
  - All outputs clear immediately and the in-flight product is discarded.
  - After release, arbitration restarts from rr_ptr=0.
- rsp_ready high while rsp_valid is low is ignored.

Test Plan:
1. Single request. Reset, then req0 with a=12, b=13 accepted at edge T (MULT_LATENCY=1, registered multiplier model) -> rsp_valid rises at T+2 with rsp_data=156, rsp_id=0; busy=1 from T until the response handshake.
2. All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each response carries its own operands (a=i+1, b=10, so rsp_data=10,20,30,40,10).
3. Backpressure. rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data and rsp_id stable, req_ready stays 0 while req1 is pending; raise rsp_ready -> IDLE next cycle, req1 granted the cycle after.
4. Boundary values. a=255, b=255 -> rsp_data=16'hFE01. a=0, b=200 -> 0. Repeat with MULT_LATENCY=0 and MULT_LATENCY=3 -> rsp_valid rises at T+1 and T+4 respectively.
5. Reset mid-operation. pReset asserted in WAIT -> busy, rsp_valid and mult_8_a/b go to 0 without waiting for a clock edge. After release, req2 and req0 both pending -> req0 granted first (rr_ptr=0).
6. Fairness under sparse traffic. req3 granted, then only req1 valid -> req1 granted (wrap search). Then req1 and req2 valid -> req2 granted first (rr_ptr=2).

Source files
------------

// File: rtl/mult_8_share_arbiter.sv
// mult_8_share_arbiter: round-robin front end that shares a single mult_8 tile
// between N_REQ requesters. One operand pair is accepted at a time. The block
// waits out the tile latency, captures the product and returns it tagged with
// the index of the requester that supplied the operands.
module mult_8_share_arbiter #(
    parameter int N_REQ        = 4,
    parameter int ID_W         = 2,
    parameter int MULT_LATENCY = 1
) (
    input  logic                 mult_8_clk,
    input  logic                 pReset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic [7:0]           mult_8_a,
    output logic [7:0]           mult_8_b,
    input  logic [15:0]          mult_8_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);

    // Counter is wide enough for MULT_LATENCY, and at least one bit when it is 0.
    localparam int               CNT_W    = $clog2(MULT_LATENCY + 2);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MULT_LATENCY);

    // Elaboration-time sanity checks on the parameter set.
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("mult_8_share_arbiter: N_REQ must be in 2..8");
    end
    if (ID_W != $clog2(N_REQ)) begin : g_bad_idw
        $error("mult_8_share_arbiter: ID_W must equal clog2(N_REQ)");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        op_a_q;
    logic [7:0]        op_b_q;
    logic              rsp_valid_q;
    logic [15:0]       rsp_data_q;
    logic [ID_W-1:0]   rsp_id_q;

    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic [7:0]        grant_a;
    logic [7:0]        grant_b;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int j;
        j         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_a   = '0;
        grant_b   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!grant_vld && req_valid[j]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(j);
                grant_a   = req_a[8*j +: 8];
                grant_b   = req_b[8*j +: 8];
            end
        end
    end

    // Pointer moves to the requester just after the winner, wrapping at N_REQ.
    always_comb begin
        if (int'(grant_idx) == N_REQ - 1) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = grant_idx + 1'b1;
        end
    end

    // Ready is a one-hot echo of the grant, only while idle.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Sequencer: accept one pair, wait the tile latency, hold the result until taken.
    always_ff @(posedge mult_8_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        op_a_q   <= grant_a;
                        op_b_q   <= grant_b;
                        rsp_id_q <= grant_idx;
                        rr_ptr_q <= rr_ptr_d;
                        cnt_q    <= LAT_INIT;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Zero count means the tile output now reflects the held operands.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rsp_data_q  <= mult_8_out;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    // rsp_valid is always high here, so rsp_ready alone completes the handshake.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mult_8_a  = op_a_q;
    assign mult_8_b  = op_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_8_share_arbiter.sv
// Directed bench for mult_8_share_arbiter. Instance 0 uses a one-stage tile
// model, instance 1 a combinational tile, instance 2 a three-stage tile.
module tb_mult_8_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rv    [3];
    logic [3:0]  rrdy  [3];
    logic [31:0] ra    [3];
    logic [31:0] rb    [3];
    logic [7:0]  ma    [3];
    logic [7:0]  mb    [3];
    logic [15:0] mo    [3];
    logic        rsvld [3];
    logic        rsrdy [3];
    logic [15:0] rsd   [3];
    logic [1:0]  rsid  [3];
    logic        bsy   [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar d = 0; d < 3; d++) begin : g_dut
        localparam int LAT = (d == 0) ? 1 : ((d == 1) ? 0 : 3);

        mult_8_share_arbiter #(
            .N_REQ(4), .ID_W(2), .MULT_LATENCY(LAT)
        ) u_dut (
            .mult_8_clk (clk),
            .pReset     (rst),
            .req_valid  (rv[d]),
            .req_ready  (rrdy[d]),
            .req_a      (ra[d]),
            .req_b      (rb[d]),
            .mult_8_a   (ma[d]),
            .mult_8_b   (mb[d]),
            .mult_8_out (mo[d]),
            .rsp_valid  (rsvld[d]),
            .rsp_ready  (rsrdy[d]),
            .rsp_data   (rsd[d]),
            .rsp_id     (rsid[d]),
            .busy       (bsy[d])
        );

        // Tile model: unsigned 8x8 product, delayed by LAT clock edges.
        if (LAT == 0) begin : g_comb
            assign mo[d] = {8'h00, ma[d]} * {8'h00, mb[d]};
        end else begin : g_pipe
            logic [15:0] pipe [LAT];
            always_ff @(posedge clk) begin
                pipe[0] <= {8'h00, ma[d]} * {8'h00, mb[d]};
                for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
            end
            assign mo[d] = pipe[LAT-1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance negedge by negedge until rsp_valid is seen (bounded).
    task automatic wait_rsp(input int d, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsvld[d] && cyc < 40);
        chk("rsp_valid_arrives", 32'(rsvld[d]), 1);
    endtask

    // One complete transaction with rsp_ready held high; checks latency, data, id.
    task automatic xact(input int d, input int g, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int exp_cyc, input string tag);
        int cyc;
        @(negedge clk);
        ra[d][8*g +: 8] = a;
        rb[d][8*g +: 8] = b;
        rv[d]    = 4'b0001 << g;
        rsrdy[d] = 1'b1;
        wait_rsp(d, cyc);
        rv[d] = '0;
        chk({tag, "_lat"},  cyc, exp_cyc);
        chk({tag, "_data"}, 32'(rsd[d]), 32'(exp));
        chk({tag, "_id"},   32'(rsid[d]), g);
        @(negedge clk);
        chk({tag, "_done"}, {30'd0, bsy[d], rsvld[d]}, 0);
        rsrdy[d] = 1'b0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            rv[d] = '0; ra[d] = '0; rb[d] = '0; rsrdy[d] = 1'b0;
        end

        // Reset state
        @(negedge clk);
        chk("rst_busy", 32'(bsy[0]), 0);
        chk("rst_rsp_valid", 32'(rsvld[0]), 0);
        chk("rst_mult_a", 32'(ma[0]), 0);
        chk("rst_mult_b", 32'(mb[0]), 0);
        chk("rst_rsp_data", 32'(rsd[0]), 0);
        chk("rst_rsp_id", 32'(rsid[0]), 0);
        chk("rst_req_ready", 32'(rrdy[0]), 0);
        rst = 1'b0;

        // 1: single request, 12*13
        @(negedge clk);
        rv[0] = 4'b0001; ra[0][7:0] = 8'd12; rb[0][7:0] = 8'd13;
        #1;
        chk("t1_req_ready", 32'(rrdy[0]), 32'b0001);
        chk("t1_idle_busy", 32'(bsy[0]), 0);
        @(negedge clk);
        chk("t1_busy", 32'(bsy[0]), 1);
        chk("t1_mult_a", 32'(ma[0]), 12);
        chk("t1_mult_b", 32'(mb[0]), 13);
        chk("t1_ready_in_wait", 32'(rrdy[0]), 0);
        rv[0] = '0;
        @(negedge clk);
        chk("t1_not_yet_valid", 32'(rsvld[0]), 0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsvld[0]), 1);
        chk("t1_rsp_data", 32'(rsd[0]), 156);
        chk("t1_rsp_id", 32'(rsid[0]), 0);
        chk("t1_busy_resp", 32'(bsy[0]), 1);
        rsrdy[0] = 1'b1;
        @(negedge clk);
        chk("t1_after_hs_valid", 32'(rsvld[0]), 0);
        chk("t1_after_hs_busy", 32'(bsy[0]), 0);
        chk("t1_mult_a_held", 32'(ma[0]), 12);
        rsrdy[0] = 1'b0;

        // 2: all requesters valid, round-robin order 0,1,2,3,0
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        ra[0] = {8'd4, 8'd3, 8'd2, 8'd1};
        rb[0] = {8'd10, 8'd10, 8'd10, 8'd10};
        rsrdy[0] = 1'b1;
        rv[0] = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(0, cyc);
            if (k == 4) rv[0] = '0;
            chk("t2_rr_id", 32'(rsid[0]), k % 4);
            chk("t2_rr_data", 32'(rsd[0]), 10 * ((k % 4) + 1));
        end
        @(negedge clk);
        rsrdy[0] = 1'b0;

        // 3: backpressure with req1 pending (rr_ptr=1, only req0 valid first)
        @(negedge clk);
        ra[0][7:0] = 8'd7; rb[0][7:0] = 8'd9; rv[0] = 4'b0001;
        #1;
        chk("t3_grant0", 32'(rrdy[0]), 32'b0001);
        @(negedge clk);
        rv[0] = 4'b0010; ra[0][15:8] = 8'd2; rb[0][15:8] = 8'd10;
        wait_rsp(0, cyc);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_data", 32'(rsd[0]), 63);
            chk("t3_hold_id", 32'(rsid[0]), 0);
            chk("t3_hold_ready", 32'(rrdy[0]), 0);
            @(negedge clk);
        end
        chk("t3_still_valid", 32'(rsvld[0]), 1);
        rsrdy[0] = 1'b1;
        #1;
        chk("t3_ready_in_resp", 32'(rrdy[0]), 0);
        @(negedge clk);
        rsrdy[0] = 1'b0;
        chk("t3_idle_valid", 32'(rsvld[0]), 0);
        chk("t3_idle_busy", 32'(bsy[0]), 0);
        chk("t3_grant1", 32'(rrdy[0]), 32'b0010);
        @(negedge clk);
        chk("t3_busy1", 32'(bsy[0]), 1);
        chk("t3_mult_a1", 32'(ma[0]), 2);
        rsrdy[0] = 1'b1;
        wait_rsp(0, cyc);
        rv[0] = '0;
        chk("t3_data1", 32'(rsd[0]), 20);
        chk("t3_id1", 32'(rsid[0]), 1);
        @(negedge clk);
        rsrdy[0] = 1'b0;

        // 4: boundary operands across latencies 1, 0, 3
        xact(0, 0, 8'd255, 8'd255, 16'hFE01, 3, "t4_l1_max");
        xact(0, 0, 8'd0,   8'd200, 16'h0000, 3, "t4_l1_zero");
        xact(1, 0, 8'd255, 8'd255, 16'hFE01, 2, "t4_l0_max");
        xact(1, 2, 8'd0,   8'd200, 16'h0000, 2, "t4_l0_zero");
        xact(2, 0, 8'd255, 8'd255, 16'hFE01, 5, "t4_l3_max");
        xact(2, 3, 8'd0,   8'd200, 16'h0000, 5, "t4_l3_zero");

        // 5: reset asserted while waiting on the tile
        @(negedge clk);
        ra[0][23:16] = 8'd5; rb[0][23:16] = 8'd6; rv[0] = 4'b0100;
        @(negedge clk);
        chk("t5_busy_wait", 32'(bsy[0]), 1);
        chk("t5_mult_a_wait", 32'(ma[0]), 5);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_busy", 32'(bsy[0]), 0);
        chk("t5_async_valid", 32'(rsvld[0]), 0);
        chk("t5_async_mult_a", 32'(ma[0]), 0);
        chk("t5_async_mult_b", 32'(mb[0]), 0);
        rv[0] = 4'b0101; ra[0][7:0] = 8'd3; rb[0][7:0] = 8'd4;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_grant0_first", 32'(rrdy[0]), 32'b0001);
        rsrdy[0] = 1'b1;
        wait_rsp(0, cyc);
        rv[0] = 4'b0100;
        chk("t5_id0", 32'(rsid[0]), 0);
        chk("t5_data0", 32'(rsd[0]), 12);
        wait_rsp(0, cyc);
        rv[0] = '0;
        chk("t5_id2", 32'(rsid[0]), 2);
        chk("t5_data2", 32'(rsd[0]), 30);
        @(negedge clk);
        rsrdy[0] = 1'b0;

        // 6: sparse traffic fairness (rr_ptr=3 here)
        xact(0, 3, 8'd9, 8'd9, 16'd81, 3, "t6_req3");
        xact(0, 1, 8'd8, 8'd8, 16'd64, 3, "t6_req1_wrap");
        @(negedge clk);
        ra[0][15:8] = 8'd11; rb[0][15:8] = 8'd2;
        ra[0][23:16] = 8'd20; rb[0][23:16] = 8'd3;
        rv[0] = 4'b0110;
        #1;
        chk("t6_grant2_first", 32'(rrdy[0]), 32'b0100);
        rsrdy[0] = 1'b1;
        wait_rsp(0, cyc);
        rv[0] = '0;
        chk("t6_id2", 32'(rsid[0]), 2);
        chk("t6_data2", 32'(rsd[0]), 60);
        @(negedge clk);
        rsrdy[0] = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
